// File: rtl/cache_fill_fsm.sv
// Cache-miss block fill controller: one word read per cycle, one write per valid, one tag write.
// Optional critical-word-first ordering when CRIT_WORD_FIRST_EN is defined.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              mem_read,
    output logic [ADDR_W-1:0] memory_address,
    input  logic [15:0]       memory_data,
    input  logic              memory_data_valid,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] cache_word_addr,
    output logic [15:0]       cache_data,
`ifdef CRIT_WORD_FIRST_EN
    output logic              crit_word_valid,
`endif
    output logic              write_tag_array
);

    localparam int LW = $clog2(BLOCK_WORDS);
    localparam int CW = LW + 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << (LW + 1)) - 1);

    if (BLOCK_WORDS < 2 || BLOCK_WORDS > 16 ||
        (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0 || MEM_LATENCY < 1) begin : g_bad_cfg
        $error("cache_fill_fsm: unsupported parameter set");
    end

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     issue_cnt, issue_d;
    logic [CW-1:0]     recv_cnt, recv_d;
    logic [ADDR_W-1:0] blk, blk_d;
    logic [LW-1:0]     issue_idx, recv_idx;
    logic [LW-1:0]     w0, w0_d;

    function automatic logic [ADDR_W-1:0] word_off(input logic [LW-1:0] idx);
        return ADDR_W'({idx, 1'b0});
    endfunction

    assign cache_data = memory_data;

`ifdef CRIT_WORD_FIRST_EN
    assign w0_d = miss_address[LW:1];
`else
    assign w0_d = '0;
`endif

    // Once all requests are out the issue index freezes on the last word.
    always_comb begin
        issue_idx = issue_cnt[LW-1:0];
        if (issue_cnt == CW'(BLOCK_WORDS)) begin
            issue_idx = LW'(BLOCK_WORDS - 1);
        end
        issue_idx = issue_idx + w0;
        recv_idx  = recv_cnt[LW-1:0] + w0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            blk       <= '0;
            w0        <= '0;
        end else begin
            state     <= state_d;
            issue_cnt <= issue_d;
            recv_cnt  <= recv_d;
            blk       <= blk_d;
            if (state == IDLE && miss_detected) begin
                w0 <= w0_d;
            end
        end
    end

    always_comb begin
        state_d          = state;
        issue_d          = issue_cnt;
        recv_d           = recv_cnt;
        blk_d            = blk;
        fsm_busy         = 1'b0;
        mem_read         = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        cache_word_addr  = '0;
        write_tag_array  = 1'b0;
`ifdef CRIT_WORD_FIRST_EN
        crit_word_valid  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    state_d = FILL;
                    blk_d   = miss_address & ~OFF_MASK;
                    issue_d = '0;
                    recv_d  = '0;
                end
            end
            FILL: begin
                fsm_busy         = 1'b1;
                mem_read         = issue_cnt < CW'(BLOCK_WORDS);
                memory_address   = blk | word_off(issue_idx);
                write_data_array = memory_data_valid;
                cache_word_addr  = blk | word_off(recv_idx);
                if (mem_read) begin
                    issue_d = issue_cnt + 1'b1;
                end
                if (memory_data_valid) begin
                    recv_d = recv_cnt + 1'b1;
`ifdef CRIT_WORD_FIRST_EN
                    crit_word_valid = recv_cnt == '0;
`endif
                    if (recv_cnt == CW'(BLOCK_WORDS - 1)) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm (BLOCK_WORDS=8, MEM_LATENCY=4).
// Memory returns are driven by hand from the bench's own schedule.
module tb_cache_fill_fsm;

    localparam int BW  = 8;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        mem_read;
    logic [15:0] memory_address;
    logic [15:0] memory_data;
    logic        vld;
    logic        write_data_array;
    logic [15:0] cache_word_addr;
    logic [15:0] cache_data;
    logic        write_tag_array;
`ifdef CRIT_WORD_FIRST_EN
    logic        crit_word_valid;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    cache_fill_fsm #(.BLOCK_WORDS(BW), .MEM_LATENCY(LAT), .ADDR_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .mem_read          (mem_read),
        .memory_address    (memory_address),
        .memory_data       (memory_data),
        .memory_data_valid (vld),
        .write_data_array  (write_data_array),
        .cache_word_addr   (cache_word_addr),
        .cache_data        (cache_data),
`ifdef CRIT_WORD_FIRST_EN
        .crit_word_valid   (crit_word_valid),
`endif
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        miss;
        logic [15:0] maddr;
        logic        vld;
        logic [15:0] data;
        logic        busy;
        logic        rd;
        logic [15:0] ma;
        logic        wda;
        logic [15:0] cwa;
        logic        tag;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [15:0] wa(input logic [15:0] a, input int i);
        int w0;
`ifdef CRIT_WORD_FIRST_EN
        w0 = int'(a[3:1]);
`else
        w0 = 0;
`endif
        return (a & 16'hFFF0) | 16'(((w0 + i) % BW) * 2);
    endfunction

    function automatic logic [51:0] ev(input logic b, input logic r,
                                       input logic [15:0] m, input logic w,
                                       input logic [15:0] c, input logic t,
                                       input logic [15:0] d);
        return {b, r, m, w, c, t, d};
    endfunction

    function automatic logic [51:0] obs();
        return {fsm_busy, mem_read, memory_address, write_data_array,
                cache_word_addr, write_tag_array, cache_data};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int vc(input int k, input int gap);
        return LAT + k + ((gap >= 0 && k > gap) ? 2 : 0);
    endfunction

    // Miss cycle, then every FILL cycle up to the tag write.
    task automatic fill(input logic [15:0] a, input int gap, input int noise);
        int r;
        logic v;
        @(negedge clk);
        miss = 1'b1; miss_address = a; vld = 1'b0; memory_data = 16'h0;
        #1 chk($sformatf("miss %h", a), 64'(obs()), 64'(ev(1, 0, 0, 0, 0, 0, 0)));
        r = 0;
        for (int c = 0; c <= vc(BW - 1, gap); c++) begin
            @(negedge clk);
            miss         = (c == noise);
            miss_address = (c == noise) ? 16'h5678 : a;
            v            = (r < BW) && (c == vc(r, gap));
            vld          = v;
            memory_data  = 16'hD000 + 16'(c);
            #1;
            chk($sformatf("fill %h c%0d", a, c), 64'(obs()),
                64'(ev(1, c < BW, wa(a, (c < BW) ? c : BW - 1), v,
                       wa(a, r), v && r == BW - 1, memory_data)));
`ifdef CRIT_WORD_FIRST_EN
            chk($sformatf("crit %h c%0d", a, c), 64'(crit_word_valid), 64'(v && r == 0));
`endif
            if (v) r++;
        end
    endtask

    task automatic idle_chk(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            miss = 1'b0; vld = i[0]; memory_data = 16'hE000 + 16'(i);
            #1 chk($sformatf("%s %0d", name, i), 64'(obs()),
                   64'(ev(0, 0, 0, 0, 0, 0, memory_data)));
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 16'h1234, 1'b0, 16'h0,
                   1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0};
        for (int c = 0; c < 12; c++) begin
            tbl[c+1] = '{1'b0, 16'h1234, c >= 4, 16'hC000 + 16'(c),
                         1'b1, c < 8, wa(16'h1234, (c < 8) ? c : 7),
                         c >= 4, wa(16'h1234, (c < 4) ? 0 : c - 4), c == 11};
        end
        tbl[13] = '{1'b0, 16'h1234, 1'b0, 16'h0,
                    1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0};

        rst = 1'b1; miss = 1'b0; miss_address = 16'h0;
        vld = 1'b1; memory_data = 16'h1111;
        @(negedge clk);
        #1 chk("reset", 64'(obs()), 64'(ev(0, 0, 0, 0, 0, 0, 16'h1111)));
        @(negedge clk);
        rst = 1'b0; vld = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            miss = tbl[i].miss; miss_address = tbl[i].maddr;
            vld = tbl[i].vld; memory_data = tbl[i].data;
            #1 chk($sformatf("basic row %0d", i), 64'(obs()),
                   64'(ev(tbl[i].busy, tbl[i].rd, tbl[i].ma, tbl[i].wda,
                          tbl[i].cwa, tbl[i].tag, tbl[i].data)));
        end

        fill(16'h1234, -1, 2);
        fill(16'h5678, -1, -1);
        idle_chk("post stall", 1);

        // Reset after three returned words.
        @(negedge clk);
        miss = 1'b1; miss_address = 16'h1234; vld = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            miss = 1'b0; vld = (c >= 4); memory_data = 16'hA000 + 16'(c);
        end
        @(negedge clk);
        vld = 1'b1; memory_data = 16'hBEEF; rst = 1'b1;
        #1 chk("rst midfill", 64'(obs()), 64'(ev(0, 0, 0, 0, 0, 0, 16'hBEEF)));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vld = 1'b1; memory_data = 16'h5A00 + 16'(i);
            #1 chk($sformatf("stray %0d", i), 64'(obs()),
                   64'(ev(0, 0, 0, 0, 0, 0, memory_data)));
        end
        fill(16'h0000, -1, -1);
        idle_chk("post rst", 1);

        fill(16'h2468, 3, -1);
        idle_chk("post gap", 1);

        idle_chk("idle noise", 6);

`ifdef CRIT_WORD_FIRST_EN
        fill(16'h123A, -1, -1);
        idle_chk("post crit", 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
